// File: rtl/debug_step_display_pkg.sv
// debug_step_display_pkg: shared FSM encoding, blank pattern and index-width helpers.
// Used by debug_step_display; holds no ports.
package debug_step_display_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_BLANK, ST_SHOW, ST_STEP} state_t;
  localparam logic [63:0] BLANK_PATTERN = '1;
  function automatic int num_segs(input int data_w, input int led_w);
    return (data_w + led_w - 1) / led_w;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debug_step_display_step_sync_edge.sv
// debug_step_display_step_sync_edge: synchronises the step switch, detects rising edges, holds a pending flag.
// Ports: clk, reset_n (sync, active-low), step_sw (async), consume (clears flag), pending (queued step).
module debug_step_display_step_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic step_sw,
  input  logic consume,
  output logic pending
);
  logic [2:0] sync;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync    <= '0;
      pending <= 1'b0;
    end else begin
      sync    <= {sync[1:0], step_sw};
      pending <= consume ? 1'b0 : pending | (sync[1] & ~sync[2]);
    end
  end
endmodule

// File: rtl/debug_step_display.sv
// debug_step_display: clock-enable stepping of a multicycle CPU, pausing at fetch to page debug words onto LEDs.
// Ports: clk, reset_n (sync, active-low), cu_state, dbg_data (NUM_CH words), step_sw, run_mode,
//        cpu_en (CPU clock enable), led_out, paused, frame_done.
module debug_step_display
  import debug_step_display_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LED_W       = 16,
  parameter int NUM_CH      = 2,
  parameter int STATE_W     = 6,
  parameter int FETCH_STATE = 0,
  parameter int DIV_W       = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [STATE_W-1:0]       cu_state,
  input  logic [NUM_CH*DATA_W-1:0] dbg_data,
  input  logic                     step_sw,
  input  logic                     run_mode,
  output logic                     cpu_en,
  output logic [LED_W-1:0]         led_out,
  output logic                     paused,
  output logic                     frame_done
);
  localparam int SEGS = num_segs(DATA_W, LED_W);
  localparam int SEG_W = idx_w(SEGS);
  localparam int CH_W = idx_w(NUM_CH);
  localparam logic [SEG_W-1:0] SEG_TOP = SEG_W'(SEGS - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [LED_W-1:0] BLANK = BLANK_PATTERN[LED_W-1:0];
  state_t state;
  logic [DIV_W-1:0] div_cnt;
  logic [CH_W-1:0] ch, nch;
  logic [SEG_W-1:0] seg, nseg;
  logic [DATA_W-1:0] word;
  logic [SEGS*LED_W-1:0] wide;
  logic [LED_W-1:0] nslice, state_led;
  logic tick, frame_end, resume, pending, consume;
  assign tick = &div_cnt;
  assign frame_end = state == ST_SHOW && ch == CH_LAST && seg == '0;
  assign resume = run_mode || pending;
  assign consume = tick && frame_end && resume;
  assign state_led = LED_W'(cu_state);
  debug_step_display_step_sync_edge u_step (
    .clk     (clk),
    .reset_n (reset_n),
    .step_sw (step_sw),
    .consume (consume),
    .pending (pending)
  );
  // Indices of the slice to show after this tick: BLANK restarts at the top slice of channel 0.
  always_comb begin
    nch = state != ST_SHOW ? '0 : seg == '0 ? ch + 1'b1 : ch;
    nseg = (state != ST_SHOW || seg == '0) ? SEG_TOP : seg - 1'b1;
    word = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (nch == CH_W'(k)) word = dbg_data[k*DATA_W +: DATA_W];
    wide = '0;
    wide[DATA_W-1:0] = word;
    nslice = '0;
    for (int s = 0; s < SEGS; s++)
      if (nseg == SEG_W'(s)) nslice = wide[s*LED_W +: LED_W];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      state      <= ST_RUN;
      ch         <= '0;
      seg        <= '0;
      led_out    <= BLANK;
      cpu_en     <= 1'b0;
      paused     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
      cpu_en     <= 1'b0;
      frame_done <= 1'b0;
      if (tick) begin
        case (state)
          ST_RUN: begin
            if (cu_state == STATE_W'(FETCH_STATE)) begin
              state   <= ST_BLANK;
              paused  <= 1'b1;
              led_out <= BLANK;
            end else begin
              cpu_en  <= 1'b1;
              led_out <= state_led;
            end
          end
          ST_BLANK: begin
            state   <= ST_SHOW;
            ch      <= nch;
            seg     <= nseg;
            led_out <= nslice;
          end
          ST_SHOW: begin
            if (frame_end) begin
              frame_done <= 1'b1;
              state      <= resume ? ST_STEP : ST_BLANK;
              led_out    <= resume ? state_led : BLANK;
            end else begin
              ch      <= nch;
              seg     <= nseg;
              led_out <= nslice;
            end
          end
          ST_STEP: begin
            // One enable pulse moves the CPU off the fetch state before RUN checks it again.
            cpu_en  <= 1'b1;
            paused  <= 1'b0;
            state   <= ST_RUN;
            led_out <= state_led;
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end
endmodule
